// File: rtl/pc_n.sv
// Parametrised WIDTH-bit program counter with Hack-style priority control
// (clear > load > increment > hold) and a one-cycle registered wrap flag.
module pc_n #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   inc_sum;

    // The extra MSB is the carry out of the increment; it feeds only wrap.
    assign inc_sum = {1'b0, out_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        // NOTE: defaults first, so every path assigns both signals and no latch is inferred.
        out_d  = out_q;
        wrap_d = 1'b0;
        if (clr) begin
            out_d = RESET_VALUE;
        end else if (load) begin
            out_d = in;
        end else if (inc) begin
            out_d  = inc_sum[WIDTH-1:0];
            wrap_d = inc_sum[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (reset) begin
            out_q  <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_pc_n.sv
// Self-checking bench for pc_n: directed boundary steps on a 16-bit and a
// 4-bit instance, then randomised traffic against a behavioural model.
module tb_pc_n;

    logic        clk;
    logic        reset;
    logic        clr16, load16, inc16;
    logic [15:0] in16, out16;
    logic        wrap16;
    logic        clr4, load4, inc4;
    logic [3:0]  in4, out4;
    logic        wrap4;

    int n_checks = 0;
    int n_fail   = 0;

    int m16, m4;
    bit w16, w4;

    pc_n dut16 (
        .clk  (clk),
        .reset(reset),
        .clr  (clr16),
        .load (load16),
        .inc  (inc16),
        .in   (in16),
        .out  (out16),
        .wrap (wrap16)
    );

    pc_n #(.WIDTH(4), .RESET_VALUE(4'hA)) dut4 (
        .clk  (clk),
        .reset(reset),
        .clr  (clr4),
        .load (load4),
        .inc  (inc4),
        .in   (in4),
        .out  (out4),
        .wrap (wrap4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour: plain integer arithmetic modulo 2^width.
    task automatic model_step(input int width, input int rv, input bit c, input bit l,
                              input bit i, input int din, inout int m, inout bit w);
        int max_val;
        max_val = (1 << width) - 1;
        if (c) begin
            m = rv;
            w = 1'b0;
        end else if (l) begin
            m = din;
            w = 1'b0;
        end else if (i) begin
            w = (m == max_val);
            m = (m + 1) % (max_val + 1);
        end else begin
            w = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        {clr16, load16, inc16} = 3'b000;
        {clr4, load4, inc4}    = 3'b000;
        in16 = 16'h0;
        in4  = 4'h0;

        #3;
        check("reset_out16", 32'(out16), 32'h0);
        check("reset_wrap16", 32'(wrap16), 32'h0);
        check("reset_out4", 32'(out4), 32'hA);

        // Reset overrides every control across a clock edge.
        {clr16, load16, inc16} = 3'b011;
        in16 = 16'h5555;
        step();
        check("reset_hold_out16", 32'(out16), 32'h0);
        {clr16, load16, inc16} = 3'b000;
        reset = 1'b0;

        // Mid-cycle async reset, then back-to-back increments.
        load16 = 1'b1;
        in16   = 16'h1234;
        step();
        check("load_1234", 32'(out16), 32'h1234);
        load16 = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_out", 32'(out16), 32'h0);
        check("async_reset_wrap", 32'(wrap16), 32'h0);
        #1 reset = 1'b0;
        inc16 = 1'b1;
        step();
        check("inc_1", 32'(out16), 32'h1);
        step();
        check("inc_2", 32'(out16), 32'h2);
        step();
        check("inc_3", 32'(out16), 32'h3);

        // Priority ordering.
        {clr16, load16, inc16} = 3'b010;
        in16 = 16'h0010;
        step();
        check("prio_pre", 32'(out16), 32'h0010);
        {clr16, load16, inc16} = 3'b111;
        in16 = 16'hBEEF;
        step();
        check("prio_clr_wins", 32'(out16), 32'h0);
        {clr16, load16, inc16} = 3'b011;
        step();
        check("prio_load_wins", 32'(out16), 32'hBEEF);
        {clr16, load16, inc16} = 3'b000;
        step();
        check("hold_1", 32'(out16), 32'hBEEF);
        step();
        check("hold_2", 32'(out16), 32'hBEEF);
        check("hold_wrap", 32'(wrap16), 32'h0);

        // Wrap boundary.
        load16 = 1'b1;
        in16   = 16'hFFFE;
        step();
        {clr16, load16, inc16} = 3'b001;
        step();
        check("wrap_out_ffff", 32'(out16), 32'hFFFF);
        check("wrap_w0", 32'(wrap16), 32'h0);
        step();
        check("wrap_out_0000", 32'(out16), 32'h0);
        check("wrap_w1", 32'(wrap16), 32'h1);
        step();
        check("wrap_out_0001", 32'(out16), 32'h1);
        check("wrap_w2", 32'(wrap16), 32'h0);

        // Load all-ones with inc in the same cycle; then clr beats inc at all-ones.
        {clr16, load16, inc16} = 3'b011;
        in16 = 16'hFFFF;
        step();
        check("load_ones_inc_out", 32'(out16), 32'hFFFF);
        check("load_ones_inc_wrap", 32'(wrap16), 32'h0);
        {clr16, load16, inc16} = 3'b101;
        step();
        check("clr_at_ones_out", 32'(out16), 32'h0);
        check("clr_at_ones_wrap", 32'(wrap16), 32'h0);

        // Async reset pulse between edges while counting.
        {clr16, load16, inc16} = 3'b010;
        in16 = 16'h00FF;
        step();
        {clr16, load16, inc16} = 3'b001;
        #2 reset = 1'b1;
        #1;
        check("cnt_reset_out", 32'(out16), 32'h0);
        check("cnt_reset_wrap", 32'(wrap16), 32'h0);
        #2 reset = 1'b0;
        step();
        check("cnt_after_reset", 32'(out16), 32'h1);
        check("cnt_after_wrap", 32'(wrap16), 32'h0);
        inc16 = 1'b0;

        // 4-bit instance with non-zero reset vector.
        check("w4_reset", 32'(out4), 32'hA);
        inc4 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("w4_inc_out", 32'(out4), 32'((4'hA + k) % 16));
            check("w4_inc_wrap", 32'(wrap4), (k == 6) ? 32'h1 : 32'h0);
        end
        {clr4, inc4} = 2'b10;
        step();
        check("w4_clr", 32'(out4), 32'hA);
        check("w4_clr_wrap", 32'(wrap4), 32'h0);
        clr4 = 1'b0;

        // Randomised traffic against the reference model.
        m16 = int'(out16);
        w16 = wrap16;
        m4  = int'(out4);
        w4  = wrap4;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            clr16  = ($urandom_range(0, 15) == 0);
            load16 = ($urandom_range(0, 7) == 0);
            inc16  = ($urandom_range(0, 3) != 0);
            in16   = $urandom_range(0, 1) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                          : 16'($urandom_range(0, 65535));
            clr4   = ($urandom_range(0, 15) == 0);
            load4  = ($urandom_range(0, 7) == 0);
            inc4   = ($urandom_range(0, 3) != 0);
            in4    = 4'($urandom_range(0, 15));
            model_step(16, 0, clr16, load16, inc16, int'(in16), m16, w16);
            model_step(4, 10, clr4, load4, inc4, int'(in4), m4, w4);
            step();
            check("rnd_out16", 32'(out16), 32'(m16));
            check("rnd_wrap16", 32'(wrap16), 32'(w16));
            check("rnd_out4", 32'(out4), 32'(m4));
            check("rnd_wrap4", 32'(wrap4), 32'(w4));
            if ($urandom_range(0, 63) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
                m16 = 0;
                w16 = 1'b0;
                m4  = 10;
                w4  = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
